// File: rtl/pds_pkg.sv
// pds_pkg: shared definitions for the PDS target responder.
//   pdsState_t  - responder FSM states
//   pdsTerm_t   - kind of bus termination a cycle ends with
//   IDX_*       - register index region boundaries
package pds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEC,
        WAIT,
        ACK,
        VPAWAIT,
        VPAE,
        BERR,
        HOLD
    } pdsState_t;

    typedef enum logic [1:0] {
        TERM_DTACK,
        TERM_VPA,
        TERM_BERR
    } pdsTerm_t;

    localparam logic [3:0] IDX_STAT     = 4'd7;
    localparam logic [3:0] IDX_VPA_LO   = 4'd8;
    localparam logic [3:0] IDX_UNMAPPED = 4'd12;

endpackage

// File: rtl/pds_regbank.sv
// pds_regbank: register bank behind the PDS responder.
//   clk, rst        - clock and synchronous active-high reset
//   wrEn            - commit strobe for one write
//   wrIdx, wrLanes  - target register and byte lanes {upper, lower}
//   wrData          - write data
//   rdIdx, rdData   - combinational read port (index 7 shows stat)
//   stat            - read-only status input
//   cfg0            - register 0 contents
module pds_regbank
    import pds_pkg::*;
#(
    parameter logic [15:0] RESET_CFG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic [3:0]  wrIdx,
    input  logic [1:0]  wrLanes,
    input  logic [15:0] wrData,
    input  logic [3:0]  rdIdx,
    input  logic [15:0] stat,
    output logic [15:0] rdData,
    output logic [15:0] cfg0
);

    // Indices 12-15 are unmapped, so only 0-11 need storage.
    logic [15:0] regs [0:11];

    always_ff @(posedge clk) begin
        if (rst) begin
            regs    <= '{default: '0};
            regs[0] <= RESET_CFG;
        end else if (wrEn && (wrIdx < IDX_UNMAPPED) && (wrIdx != IDX_STAT)) begin
            if (wrLanes[1]) regs[wrIdx][15:8] <= wrData[15:8];
            if (wrLanes[0]) regs[wrIdx][7:0]  <= wrData[7:0];
        end
    end

    always_comb begin
        rdData = '0;
        if (rdIdx == IDX_STAT)
            rdData = stat;
        else if (rdIdx < IDX_UNMAPPED)
            rdData = regs[rdIdx];
    end

    assign cfg0 = regs[0];

endmodule

// File: rtl/pds_target_responder.sv
// pds_target_responder: bus-slave end of the Mac PDS/IOB bus.
// Decodes a 32-byte window at WIN_BASE and serves a 16-entry register map.
//   C16M, RES                 - clock, synchronous active-high reset
//   A_IOB, nAS/nUDS/nLDS/nWE  - PDS address and strobes
//   nVMA_IOB, E               - 6800-style handshake inputs
//   D_IN / D_OUT, D_OE        - write data / read data and its buffer enable
//   STAT                      - read-only status, visible at index 7
//   nDTACK/nVPA/nBERR_IOBout  - terminations, driven while TERM_OE=1
//   CFG0                      - register 0 contents
module pds_target_responder
    import pds_pkg::*;
#(
    parameter logic [18:0] WIN_BASE    = 19'h7FFF8,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] RESET_CFG   = 16'h0000
) (
    input  logic        C16M,
    input  logic        RES,
    input  logic [22:0] A_IOB,
    input  logic        nAS_IOB,
    input  logic        nUDS_IOB,
    input  logic        nLDS_IOB,
    input  logic        nWE_IOB,
    input  logic        nVMA_IOB,
    input  logic        E,
    input  logic [15:0] D_IN,
    input  logic [15:0] STAT,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        nDTACK_IOBout,
    output logic        nVPA_IOBout,
    output logic        nBERR_IOBout,
    output logic        TERM_OE,
    output logic [15:0] CFG0
);

    logic        nAsR, nUdsR, nLdsR, nWeR, nVmaR, eR, eRPrev;
    logic [22:0] addrR;
    logic [15:0] dinR;

    always_ff @(posedge C16M) begin
        if (RES) begin
            nAsR   <= 1'b1;
            nUdsR  <= 1'b1;
            nLdsR  <= 1'b1;
            nWeR   <= 1'b1;
            nVmaR  <= 1'b1;
            eR     <= 1'b0;
            eRPrev <= 1'b0;
            addrR  <= '0;
            dinR   <= '0;
        end else begin
            nAsR   <= nAS_IOB;
            nUdsR  <= nUDS_IOB;
            nLdsR  <= nLDS_IOB;
            nWeR   <= nWE_IOB;
            nVmaR  <= nVMA_IOB;
            eR     <= E;
            eRPrev <= eR;
            addrR  <= A_IOB;
            dinR   <= D_IN;
        end
    end

    logic       hit, eFall;
    logic [3:0] idxIn;

    assign idxIn = addrR[3:0];
    assign hit   = !nAsR && (!nUdsR || !nLdsR) && (addrR[22:4] == WIN_BASE);
    assign eFall = eRPrev && !eR;

    pdsState_t   state, stateNext;
    pdsTerm_t    term;
    logic [3:0]  cnt, cntNext, latIdx;
    logic [1:0]  latLanes;
    logic        latWrite, load, commit;
    logic [15:0] dOutR, rdData;

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        load          = 1'b0;
        commit        = 1'b0;
        nDTACK_IOBout = 1'b1;
        nVPA_IOBout   = 1'b1;
        nBERR_IOBout  = 1'b1;
        TERM_OE       = 1'b0;
        D_OE          = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    load = 1'b1;
                    if (idxIn < IDX_VPA_LO)        stateNext = DEC;
                    else if (idxIn < IDX_UNMAPPED) stateNext = VPAWAIT;
                    else                           stateNext = BERR;
                end
            end
            DEC: begin
                if (nAsR) begin
                    stateNext = IDLE;
                end else begin
                    D_OE    = !latWrite;
                    cntNext = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        stateNext = ACK;
                        commit    = latWrite;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (nAsR) begin
                    stateNext = IDLE;
                end else begin
                    D_OE = !latWrite;
                    if (cnt == 4'd0) begin
                        stateNext = ACK;
                        commit    = latWrite;
                    end else begin
                        cntNext = cnt - 4'd1;
                    end
                end
            end
            ACK: begin
                nDTACK_IOBout = 1'b0;
                TERM_OE       = 1'b1;
                D_OE          = !latWrite;
                stateNext     = HOLD;
            end
            VPAWAIT: begin
                if (nAsR) begin
                    stateNext = IDLE;
                end else begin
                    nVPA_IOBout = 1'b0;
                    TERM_OE     = 1'b1;
                    if (!nVmaR) begin
                        D_OE      = !latWrite;
                        stateNext = VPAE;
                    end
                end
            end
            VPAE: begin
                if (nAsR) begin
                    stateNext = IDLE;
                end else begin
                    nVPA_IOBout = 1'b0;
                    TERM_OE     = 1'b1;
                    D_OE        = !latWrite;
                    if (eFall) begin
                        commit    = latWrite;
                        stateNext = HOLD;
                    end
                end
            end
            BERR: begin
                nBERR_IOBout = 1'b0;
                TERM_OE      = 1'b1;
                stateNext    = HOLD;
            end
            HOLD: begin
                // The exit cycle still drives the pins, now high, as an active pull-up.
                TERM_OE = 1'b1;
                if (nAsR) begin
                    stateNext = IDLE;
                end else begin
                    nDTACK_IOBout = !(term == TERM_DTACK);
                    nVPA_IOBout   = !(term == TERM_VPA);
                    nBERR_IOBout  = !(term == TERM_BERR);
                    D_OE          = !latWrite && (term != TERM_BERR);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Cycle attributes are captured on the decode edge so they are already
    // valid during DEC/VPAWAIT, letting reads drive D_OUT from that cycle.
    always_ff @(posedge C16M) begin
        if (RES) begin
            state    <= IDLE;
            cnt      <= '0;
            latIdx   <= '0;
            latWrite <= 1'b0;
            latLanes <= '0;
            term     <= TERM_DTACK;
            dOutR    <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (load) begin
                latIdx   <= idxIn;
                latWrite <= !nWeR;
                latLanes <= {!nUdsR, !nLdsR};
                if (idxIn < IDX_VPA_LO)        term <= TERM_DTACK;
                else if (idxIn < IDX_UNMAPPED) term <= TERM_VPA;
                else                           term <= TERM_BERR;
                if (nWeR && (idxIn < IDX_UNMAPPED))
                    dOutR <= rdData;
            end
        end
    end

    assign D_OUT = dOutR;

    pds_regbank #(
        .RESET_CFG(RESET_CFG)
    ) uRegbank (
        .clk    (C16M),
        .rst    (RES),
        .wrEn   (commit),
        .wrIdx  (latIdx),
        .wrLanes(latLanes),
        .wrData (dinR),
        .rdIdx  (idxIn),
        .stat   (STAT),
        .rdData (rdData),
        .cfg0   (CFG0)
    );

endmodule

// File: tb/tb_pds_target_responder.sv
module tb_pds_target_responder;

    localparam logic [18:0] WIN  = 19'h7FFF8;
    localparam int unsigned WS   = 2;
    localparam logic [15:0] RCFG = 16'hC35A;

    logic        C16M = 1'b0;
    logic        RES;
    logic [22:0] A_IOB;
    logic        nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB, E;
    logic [15:0] D_IN, STAT;
    logic [15:0] D_OUT, CFG0;
    logic        D_OE, nDTACK_IOBout, nVPA_IOBout, nBERR_IOBout, TERM_OE;

    int tests = 0;
    int fails = 0;

    logic [15:0] model [16];

    always #5 C16M = ~C16M;

    pds_target_responder #(
        .WIN_BASE(WIN),
        .WAIT_STATES(WS),
        .RESET_CFG(RCFG)
    ) dut (
        .C16M(C16M), .RES(RES), .A_IOB(A_IOB), .nAS_IOB(nAS_IOB),
        .nUDS_IOB(nUDS_IOB), .nLDS_IOB(nLDS_IOB), .nWE_IOB(nWE_IOB),
        .nVMA_IOB(nVMA_IOB), .E(E), .D_IN(D_IN), .STAT(STAT),
        .D_OUT(D_OUT), .D_OE(D_OE), .nDTACK_IOBout(nDTACK_IOBout),
        .nVPA_IOBout(nVPA_IOBout), .nBERR_IOBout(nBERR_IOBout),
        .TERM_OE(TERM_OE), .CFG0(CFG0)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic modelReset;
        for (int unsigned i = 0; i < 16; i++) model[i] = 16'h0000;
        model[0] = RCFG;
    endtask

    task automatic modelWrite(input logic [3:0] idx, input logic [1:0] lanes, input logic [15:0] data);
        if (idx < 4'd12 && idx != 4'd7) begin
            if (lanes[1]) model[idx][15:8] = data[15:8];
            if (lanes[0]) model[idx][7:0]  = data[7:0];
        end
    endtask

    function automatic logic [15:0] expRead(input logic [3:0] idx);
        if (idx == 4'd7) return STAT;
        if (idx >= 4'd12) return 16'h0000;
        return model[idx];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic startCycle(input logic [3:0] idx, input bit wr, input logic [1:0] lanes, input logic [15:0] data);
        @(negedge C16M);
        A_IOB    = {WIN, idx};
        nWE_IOB  = ~wr;
        D_IN     = data;
        nUDS_IOB = ~lanes[1];
        nLDS_IOB = ~lanes[0];
        nAS_IOB  = 1'b0;
    endtask

    task automatic endCycle;
        @(negedge C16M);
        nAS_IOB  = 1'b1;
        nUDS_IOB = 1'b1;
        nLDS_IOB = 1'b1;
        nWE_IOB  = 1'b1;
        nVMA_IOB = 1'b1;
    endtask

    // kind: 0 none (timeout), 1 DTACK, 2 BERR. lat counts edges after the edge sampling nAS low.
    task automatic dtackCycle(input logic [3:0] idx, input bit wr, input logic [1:0] lanes, input logic [15:0] data,
                              output int kind, output int lat, output logic [15:0] rd, output bit oe,
                              output bit oeSeen, output bit relOk);
        kind = 0; lat = 0; rd = '0; oe = 0; oeSeen = 0;
        startCycle(idx, wr, lanes, data);
        @(posedge C16M);
        for (int i = 1; i <= 30 && kind == 0; i++) begin
            @(posedge C16M); #1;
            if (D_OE) oeSeen = 1;
            if (!nDTACK_IOBout) begin kind = 1; lat = i; rd = D_OUT; oe = D_OE; end
            else if (!nBERR_IOBout) begin kind = 2; lat = i; end
        end
        endCycle;
        @(posedge C16M); #1;
        relOk = nDTACK_IOBout && nBERR_IOBout && nVPA_IOBout && !D_OE;
    endtask

    task automatic vpaCycle(input logic [3:0] idx, input bit wr, input logic [1:0] lanes, input logic [15:0] data,
                            output bit gotVpa, output int vpaLat, output bit sawDtack, output logic [15:0] rd,
                            output bit oe, output bit vpaHeld, output bit relOk);
        gotVpa = 0; vpaLat = 0; sawDtack = 0;
        nVMA_IOB = 1'b1;
        E = 1'b1;
        startCycle(idx, wr, lanes, data);
        @(posedge C16M);
        for (int i = 1; i <= 12 && !gotVpa; i++) begin
            @(posedge C16M); #1;
            if (!nDTACK_IOBout) sawDtack = 1;
            if (!nVPA_IOBout) begin gotVpa = 1; vpaLat = i; end
        end
        @(negedge C16M) nVMA_IOB = 1'b0;
        repeat (3) begin @(posedge C16M); #1; if (!nDTACK_IOBout) sawDtack = 1; end
        rd = D_OUT;
        oe = D_OE;
        @(negedge C16M) E = 1'b0;
        repeat (4) begin @(posedge C16M); #1; if (!nDTACK_IOBout) sawDtack = 1; end
        vpaHeld = !nVPA_IOBout;
        endCycle;
        @(posedge C16M); #1;
        relOk = nDTACK_IOBout && nBERR_IOBout && nVPA_IOBout && !D_OE;
        @(negedge C16M) E = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RES = 1'b1;
        repeat (2) @(posedge C16M);
        #1;
        tests++; if (nDTACK_IOBout !== 1'b1) begin fails++; $display("FAIL reset_ndtack: got %b want 1", nDTACK_IOBout); end
        tests++; if (nVPA_IOBout !== 1'b1)   begin fails++; $display("FAIL reset_nvpa: got %b want 1", nVPA_IOBout); end
        tests++; if (nBERR_IOBout !== 1'b1)  begin fails++; $display("FAIL reset_nberr: got %b want 1", nBERR_IOBout); end
        tests++; if (TERM_OE !== 1'b0)       begin fails++; $display("FAIL reset_termoe: got %b want 0", TERM_OE); end
        tests++; if (D_OE !== 1'b0)          begin fails++; $display("FAIL reset_doe: got %b want 0", D_OE); end
        tests++; if (D_OUT !== 16'h0000)     begin fails++; $display("FAIL reset_dout: got %h want 0000", D_OUT); end
        tests++; if (CFG0 !== RCFG)          begin fails++; $display("FAIL reset_cfg0: got %h want %h", CFG0, RCFG); end
        @(negedge C16M) RES = 1'b0;
        modelReset();
    endtask

    task automatic test_dtack_write;
        int kind, lat; logic [15:0] rd; bit oe, oeSeen, relOk;
        dtackCycle(4'd1, 1, 2'b11, 16'h1234, kind, lat, rd, oe, oeSeen, relOk);
        modelWrite(4'd1, 2'b11, 16'h1234);
        tests++; if (kind != 1)      begin fails++; $display("FAIL dtack_wr_kind: got %0d want 1", kind); end
        tests++; if (lat != WS + 3)  begin fails++; $display("FAIL dtack_wr_latency: got %0d want %0d", lat, WS + 3); end
        tests++; if (!relOk)         begin fails++; $display("FAIL dtack_wr_release: got %b want 1", relOk); end
        repeat (2) @(negedge C16M);
        dtackCycle(4'd1, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (kind != 1 || lat != WS + 3) begin fails++; $display("FAIL dtack_rd_term: got kind %0d lat %0d want 1/%0d", kind, lat, WS + 3); end
        tests++; if (rd !== 16'h1234 || oe !== 1'b1) begin fails++; $display("FAIL dtack_rd_data: got %h oe %b want 1234 oe 1", rd, oe); end
    endtask

    task automatic test_byte_lane;
        int kind, lat; logic [15:0] rd; bit oe, oeSeen, relOk;
        logic [15:0] junk;
        junk = {8'($urandom), 8'hAB};
        dtackCycle(4'd1, 1, 2'b01, junk, kind, lat, rd, oe, oeSeen, relOk);
        modelWrite(4'd1, 2'b01, junk);
        tests++; if (kind != 1) begin fails++; $display("FAIL lane_wr_kind: got %0d want 1", kind); end
        dtackCycle(4'd1, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (rd !== 16'h12AB) begin fails++; $display("FAIL lane_lds_only: got %h want 12AB", rd); end
        dtackCycle(4'd1, 0, 2'b10, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (rd !== 16'h12AB || oe !== 1'b1) begin fails++; $display("FAIL lane_uds_read: got %h oe %b want 12AB oe 1", rd, oe); end
    endtask

    task automatic test_vpa;
        bit got, sawDt, oe, held, relOk; int vl; logic [15:0] rd;
        vpaCycle(4'd8, 1, 2'b11, 16'h5A5A, got, vl, sawDt, rd, oe, held, relOk);
        modelWrite(4'd8, 2'b11, 16'h5A5A);
        tests++; if (!got || vl != 1) begin fails++; $display("FAIL vpa_wr_assert: got %b lat %0d want 1/1", got, vl); end
        tests++; if (sawDt)           begin fails++; $display("FAIL vpa_wr_no_dtack: got %b want 0", sawDt); end
        tests++; if (!held || !relOk) begin fails++; $display("FAIL vpa_wr_hold_release: got held %b rel %b want 1/1", held, relOk); end
        vpaCycle(4'd8, 0, 2'b11, 16'h0000, got, vl, sawDt, rd, oe, held, relOk);
        tests++; if (rd !== 16'h5A5A || oe !== 1'b1) begin fails++; $display("FAIL vpa_readback: got %h oe %b want 5A5A oe 1", rd, oe); end
    endtask

    // E falls before nVMA goes low, then the cycle is abandoned: nothing may commit.
    task automatic test_vpa_no_commit;
        bit got, sawDt, oe, held, relOk; int vl; logic [15:0] rd;
        got = 0;
        nVMA_IOB = 1'b1; E = 1'b1;
        startCycle(4'd10, 1, 2'b11, ~model[10]);
        for (int i = 0; i < 12 && !got; i++) begin @(posedge C16M); #1; if (!nVPA_IOBout) got = 1; end
        tests++; if (!got) begin fails++; $display("FAIL vpa_nc_assert: got 0 want 1"); end
        @(negedge C16M) E = 1'b0;
        repeat (3) @(negedge C16M);
        nVMA_IOB = 1'b0;
        repeat (4) @(negedge C16M);
        endCycle;
        repeat (2) @(negedge C16M);
        E = 1'b1;
        vpaCycle(4'd10, 0, 2'b11, 16'h0000, got, vl, sawDt, rd, oe, held, relOk);
        tests++; if (rd !== model[10]) begin fails++; $display("FAIL vpa_no_commit: got %h want %h", rd, model[10]); end
    endtask

    task automatic test_unmapped;
        int kind, lat; logic [15:0] rd; bit oe, oeSeen, relOk;
        dtackCycle(4'd14, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (kind != 2)        begin fails++; $display("FAIL berr_kind: got %0d want 2", kind); end
        tests++; if (oeSeen || !relOk) begin fails++; $display("FAIL berr_oe_release: got oe %b rel %b want 0/1", oeSeen, relOk); end
        dtackCycle(4'd13, 1, 2'b11, 16'hFFFF, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (CFG0 !== model[0]) begin fails++; $display("FAIL berr_cfg0: got %h want %h", CFG0, model[0]); end
        dtackCycle(4'd1, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (rd !== model[1]) begin fails++; $display("FAIL berr_reg1: got %h want %h", rd, model[1]); end
    endtask

    task automatic test_abort;
        int kind, lat; logic [15:0] rd; bit oe, oeSeen, relOk, sawTerm;
        sawTerm = 0;
        startCycle(4'd2, 1, 2'b11, ~model[2]);
        @(posedge C16M);
        repeat (2) @(posedge C16M);
        endCycle;
        repeat (6) begin
            @(posedge C16M); #1;
            if (!nDTACK_IOBout || TERM_OE || D_OE) sawTerm = 1;
        end
        tests++; if (sawTerm) begin fails++; $display("FAIL abort_outputs: got activity 1 want 0"); end
        dtackCycle(4'd2, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (rd !== model[2] || lat != WS + 3) begin fails++; $display("FAIL abort_no_commit: got %h lat %0d want %h lat %0d", rd, lat, model[2], WS + 3); end
    endtask

    task automatic test_reset_mid;
        int kind, lat; logic [15:0] rd; bit oe, oeSeen, relOk, got, sawDt, held; int vl;
        dtackCycle(4'd0, 1, 2'b11, ~RCFG, kind, lat, rd, oe, oeSeen, relOk);
        modelWrite(4'd0, 2'b11, ~RCFG);
        tests++; if (CFG0 !== model[0]) begin fails++; $display("FAIL cfg0_write: got %h want %h", CFG0, model[0]); end
        got = 0;
        nVMA_IOB = 1'b1; E = 1'b1;
        startCycle(4'd9, 1, 2'b11, 16'($urandom));
        for (int i = 0; i < 12 && !got; i++) begin @(posedge C16M); #1; if (!nVPA_IOBout) got = 1; end
        tests++; if (!got) begin fails++; $display("FAIL rstmid_vpa: got 0 want 1"); end
        @(negedge C16M) RES = 1'b1;
        @(posedge C16M); #1;
        tests++; if (nVPA_IOBout !== 1'b1 || TERM_OE !== 1'b0) begin fails++; $display("FAIL rstmid_release: got nvpa %b termoe %b want 1/0", nVPA_IOBout, TERM_OE); end
        tests++; if (CFG0 !== RCFG) begin fails++; $display("FAIL rstmid_cfg0: got %h want %h", CFG0, RCFG); end
        endCycle;
        @(negedge C16M) RES = 1'b0;
        modelReset();
        vpaCycle(4'd9, 0, 2'b11, 16'h0000, got, vl, sawDt, rd, oe, held, relOk);
        tests++; if (rd !== 16'h0000 || !got) begin fails++; $display("FAIL rstmid_no_commit: got %h want 0000", rd); end
    endtask

    task automatic test_miss_stat;
        int kind, lat; logic [15:0] rd; bit oe, oeSeen, relOk, act;
        logic [23:0] byteAddr;
        act = 0;
        byteAddr = 24'hFFFE00;
        @(negedge C16M);
        A_IOB = byteAddr[23:1]; nWE_IOB = 1'b0; nUDS_IOB = 1'b0; nLDS_IOB = 1'b0; D_IN = 16'hFFFF; nAS_IOB = 1'b0;
        repeat (12) begin
            @(posedge C16M); #1;
            if (!nDTACK_IOBout || !nVPA_IOBout || !nBERR_IOBout || TERM_OE || D_OE) act = 1;
        end
        endCycle;
        tests++; if (act) begin fails++; $display("FAIL miss_quiet: got activity 1 want 0"); end
        STAT = 16'hBEEF;
        dtackCycle(4'd7, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL stat_read: got %h want BEEF", rd); end
        dtackCycle(4'd7, 1, 2'b11, 16'h1357, kind, lat, rd, oe, oeSeen, relOk);
        STAT = 16'($urandom);
        dtackCycle(4'd7, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (rd !== STAT) begin fails++; $display("FAIL stat_write_ignored: got %h want %h", rd, STAT); end
    endtask

    task automatic test_back_to_back;
        int kind, lat; logic [15:0] rd, d; bit oe, oeSeen, relOk;
        d = 16'($urandom);
        dtackCycle(4'd3, 1, 2'b11, d, kind, lat, rd, oe, oeSeen, relOk);
        modelWrite(4'd3, 2'b11, d);
        dtackCycle(4'd3, 0, 2'b11, 16'h0000, kind, lat, rd, oe, oeSeen, relOk);
        tests++; if (kind != 1 || lat != WS + 3 || rd !== model[3]) begin
            fails++; $display("FAIL back_to_back: got kind %0d lat %0d data %h want 1/%0d/%h", kind, lat, rd, WS + 3, model[3]);
        end
    endtask

    task automatic test_random;
        int kind, lat, vl; logic [15:0] rd, d, ex; bit oe, oeSeen, relOk, got, sawDt, held, wr;
        logic [3:0] idx; logic [1:0] lanes;
        for (int unsigned n = 0; n < 30; n++) begin
            idx   = 4'($urandom_range(0, 15));
            wr    = 1'($urandom_range(0, 1));
            lanes = 2'($urandom_range(1, 3));
            d     = 16'($urandom);
            STAT  = 16'($urandom);
            ex    = expRead(idx);
            if (idx < 4'd8) begin
                dtackCycle(idx, wr, lanes, d, kind, lat, rd, oe, oeSeen, relOk);
                tests++; if (kind != 1 || lat != WS + 3 || !relOk) begin fails++; $display("FAIL rnd_dtack idx %0d: got kind %0d lat %0d rel %b want 1/%0d/1", idx, kind, lat, relOk, WS + 3); end
                if (!wr) begin
                    tests++; if (rd !== ex || !oe) begin fails++; $display("FAIL rnd_dtack_rd idx %0d: got %h oe %b want %h oe 1", idx, rd, oe, ex); end
                end
            end else if (idx < 4'd12) begin
                vpaCycle(idx, wr, lanes, d, got, vl, sawDt, rd, oe, held, relOk);
                tests++; if (!got || sawDt || !held || !relOk) begin fails++; $display("FAIL rnd_vpa idx %0d: got vpa %b dtack %b held %b rel %b want 1/0/1/1", idx, got, sawDt, held, relOk); end
                if (!wr) begin
                    tests++; if (rd !== ex || !oe) begin fails++; $display("FAIL rnd_vpa_rd idx %0d: got %h oe %b want %h oe 1", idx, rd, oe, ex); end
                end
            end else begin
                dtackCycle(idx, wr, lanes, d, kind, lat, rd, oe, oeSeen, relOk);
                tests++; if (kind != 2 || oeSeen || !relOk) begin fails++; $display("FAIL rnd_berr idx %0d: got kind %0d oe %b rel %b want 2/0/1", idx, kind, oeSeen, relOk); end
            end
            if (wr) modelWrite(idx, lanes, d);
            tests++; if (CFG0 !== model[0]) begin fails++; $display("FAIL rnd_cfg0: got %h want %h", CFG0, model[0]); end
            @(negedge C16M);
        end
    endtask

    initial begin
        RES = 1'b1; A_IOB = '0; nAS_IOB = 1'b1; nUDS_IOB = 1'b1; nLDS_IOB = 1'b1;
        nWE_IOB = 1'b1; nVMA_IOB = 1'b1; E = 1'b1; D_IN = '0; STAT = 16'h0000;
        test_reset();
        test_dtack_write();
        test_byte_lane();
        test_vpa();
        test_vpa_no_commit();
        test_unmapped();
        test_abort();
        test_reset_mid();
        test_miss_stat();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
